// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller:
// FSM state encoding, all-off pin patterns and the hex decode table.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake bundle: a producer offers a 16-bit hex value plus
// 4 decimal points; the display controller accepts it when ready.
//   load_valid/load_data/load_dp : producer -> controller
//   load_ready                   : controller -> producer
interface seven_seg_scan_ctrl_if;

   logic        load_valid;
   logic [15:0] load_data;
   logic [3:0]  load_dp;
   logic        load_ready;

   modport master (
      output load_valid,
      output load_data,
      output load_dp,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_dp,
      output load_ready
   );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
//   nib : hex digit in;  seg : {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 4-digit common-anode display scanner with anti-ghost
// blanking, leading-zero suppression and frame-synchronous loading.
//   in_clk, rst        : clock, async active-high reset
//   enable, blank_lz   : scan on/off, leading-zero suppress
//   lb (slave)         : value load handshake
//   an, seg, dp        : active-low display pins (registered)
//   frame_done         : pulse in last cycle of the digit 3 slot
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int ON_CYCLES    = 49500,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  in_clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  blank_lz,
   seven_seg_scan_ctrl_if.slave  lb,
   output logic [3:0]            an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ?
                         ON_CYCLES : BLANK_CYCLES;
   localparam int CW = $clog2(MAXC);

   localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] ON_PRE  = CW'(ON_CYCLES - 2);
   localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    digit;

   logic [15:0]   shadow;
   logic [3:0]    shadow_dp;
   logic [15:0]   pend;
   logic [3:0]    pend_dp;
   logic          pend_full;

   logic [3:0]    nib;
   logic [6:0]    nib_seg;
   logic          z3, z2, z1;
   logic [3:0]    lz_mask;
   logic          xfer;
   logic          commit;

   assign nib = shadow[{digit, 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .nib (nib),
      .seg (nib_seg)
   );

   // Digit i is suppressed when every nibble from 3 down to i is zero.
   assign z3 = (shadow[15:12] == 4'h0);
   assign z2 = (shadow[11:8]  == 4'h0);
   assign z1 = (shadow[7:4]   == 4'h0);
   assign lz_mask = {4{blank_lz}} &
                    {z3, z3 & z2, z3 & z2 & z1, 1'b0};

   assign lb.load_ready = ~pend_full;
   assign xfer   = lb.load_valid & ~pend_full;
   // Shadow only changes between frames, or at once when dark.
   assign commit = pend_full &
                   (frame_done | (state == ST_IDLE));

   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         shadow    <= '0;
         shadow_dp <= '0;
         pend      <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
      end else if (commit) begin
         shadow    <= pend;
         shadow_dp <= pend_dp;
         pend_full <= 1'b0;
      end else if (xfer) begin
         pend      <= lb.load_data;
         pend_dp   <= lb.load_dp;
         pend_full <= 1'b1;
      end
   end

   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         digit      <= '0;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
            digit <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state <= ST_BLANK;
                  cnt   <= '0;
                  digit <= '0;
                  an    <= AN_OFF;
                  seg   <= SEG_OFF;
                  dp    <= 1'b1;
               end
               ST_BLANK: begin
                  if (cnt == BL_LAST) begin
                     state <= ST_ON;
                     cnt   <= '0;
                     an    <= lz_mask[digit] ? AN_OFF :
                              ~(4'b0001 << digit);
                     seg   <= nib_seg;
                     dp    <= ~shadow_dp[digit];
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_ON: begin
                  // Registered pulse lands on the slot's last cycle.
                  if (cnt == ON_PRE && digit == 2'd3)
                     frame_done <= 1'b1;
                  if (cnt == ON_LAST) begin
                     state <= ST_BLANK;
                     cnt   <= '0;
                     digit <= digit + 2'd1;
                     an    <= AN_OFF;
                     seg   <= SEG_OFF;
                     dp    <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl, compared
// each cycle against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

   localparam int ONC   = 4;
   localparam int BLC   = 2;
   localparam int SLOT  = ONC + BLC;
   localparam int FRAME = 4 * SLOT;

   logic       in_clk   = 1'b0;
   logic       rst      = 1'b1;
   logic       enable   = 1'b0;
   logic       blank_lz = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_done;

   seven_seg_scan_ctrl_if lb ();

   seven_seg_scan_ctrl #(
      .ON_CYCLES    (ONC),
      .BLANK_CYCLES (BLC)
   ) dut (
      .in_clk     (in_clk),
      .rst        (rst),
      .enable     (enable),
      .blank_lz   (blank_lz),
      .lb         (lb),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 in_clk = ~in_clk;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   logic [6:0] seg_lut [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Reference: run flag plus position inside the 24-cycle frame.
   bit          run    = 1'b0;
   int          pos    = 0;
   logic [15:0] m_sh   = '0;
   logic [3:0]  m_shdp = '0;
   logic [15:0] m_pd   = '0;
   logic [3:0]  m_pddp = '0;
   bit          m_full = 1'b0;

   always @(posedge in_clk or posedge rst) begin
      if (rst) begin
         run    <= 1'b0;
         pos    <= 0;
         m_sh   <= '0;
         m_shdp <= '0;
         m_full <= 1'b0;
      end else begin
         if (m_full && (!run || pos == FRAME - 1)) begin
            m_sh   <= m_pd;
            m_shdp <= m_pddp;
            m_full <= 1'b0;
         end else if (lb.load_valid && !m_full) begin
            m_pd   <= lb.load_data;
            m_pddp <= lb.load_dp;
            m_full <= 1'b1;
         end
         if (!enable) begin
            run <= 1'b0;
            pos <= 0;
         end else if (!run) begin
            run <= 1'b1;
            pos <= 0;
         end else begin
            pos <= (pos + 1) % FRAME;
         end
      end
   end

   int         d;
   logic [3:0] ea;
   logic [6:0] es;
   logic       ed;

   always @(negedge in_clk) begin
      ea = 4'hF;
      es = 7'h7F;
      ed = 1'b1;
      if (run && (pos % SLOT) >= BLC) begin
         d  = pos / SLOT;
         es = seg_lut[m_sh[d*4 +: 4]];
         ed = ~m_shdp[d];
         if (blank_lz && d >= 1 && (m_sh >> (4 * d)) == 16'h0)
            ea = 4'hF;
         else
            ea = ~(4'b0001 << d);
      end
      check_eq("an", 32'(an), 32'(ea));
      check_eq("seg", 32'(seg), 32'(es));
      check_eq("dp", 32'(dp), 32'(ed));
      check_eq("frame_done", 32'(frame_done),
               32'(run && pos == FRAME - 1));
      check_eq("load_ready", 32'(lb.load_ready), 32'(!m_full));
   end

   task automatic wait_on(input int dg);
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge in_clk);
         if (run && pos / SLOT == dg && pos % SLOT == BLC + 1) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) check_eq("wait_on_timeout", 0, 1);
   endtask

   task automatic offer(input logic [15:0] v, input logic [3:0] p);
      bit ok = 1'b0;
      lb.load_valid = 1'b1;
      lb.load_data  = v;
      lb.load_dp    = p;
      for (int i = 0; i < 200; i++) begin
         if (lb.load_ready) ok = 1'b1;
         @(negedge in_clk);
         if (ok) break;
      end
      if (!ok) check_eq("load_timeout", 0, 1);
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] p);
      offer(v, p);
      lb.load_valid = 1'b0;
   endtask

   initial begin
      int fd_cnt;
      bit got_fd;
      lb.load_valid = 1'b0;
      lb.load_data  = '0;
      lb.load_dp    = '0;

      repeat (3) @(negedge in_clk);
      rst = 1'b0;
      @(negedge in_clk);
      enable = 1'b1;

      wait_on(2);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_an", 32'(an), 32'hF);
      check_eq("rst_seg", 32'(seg), 32'h7F);
      check_eq("rst_dp", 32'(dp), 32'h1);
      check_eq("rst_ready", 32'(lb.load_ready), 32'h1);
      check_eq("rst_fd", 32'(frame_done), 32'h0);
      @(negedge in_clk);
      rst = 1'b0;
      repeat (4) @(negedge in_clk);

      load_word(16'h12AF, 4'b0001);
      repeat (2 * FRAME) @(negedge in_clk);

      enable = 1'b0;
      @(negedge in_clk);
      blank_lz = 1'b1;
      load_word(16'h0005, 4'b0000);
      enable = 1'b1;
      repeat (FRAME + 4) @(negedge in_clk);
      load_word(16'h0000, 4'b0010);
      repeat (2 * FRAME) @(negedge in_clk);
      enable = 1'b0;
      @(negedge in_clk);
      blank_lz = 1'b0;
      @(negedge in_clk);
      enable = 1'b1;

      offer(16'hBEEF, 4'b1010);
      offer(16'h3C70, 4'b0101);
      lb.load_valid = 1'b0;
      repeat (2 * FRAME) @(negedge in_clk);

      wait_on(2);
      enable = 1'b0;
      repeat (3) @(negedge in_clk);
      enable = 1'b1;
      repeat (FRAME) @(negedge in_clk);

      for (int c = 0; c < 800; c++) begin
         @(negedge in_clk);
         lb.load_valid = ($urandom_range(0, 3) == 0);
         lb.load_data  = 16'($urandom);
         lb.load_dp    = 4'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            enable = 1'b0;
            @(negedge in_clk);
            blank_lz = 1'($urandom_range(0, 1));
            @(negedge in_clk);
            enable = 1'b1;
         end
      end
      lb.load_valid = 1'b0;

      got_fd = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge in_clk);
         if (frame_done) begin
            got_fd = 1'b1;
            break;
         end
      end
      if (!got_fd) check_eq("fd_timeout", 0, 1);
      fd_cnt = 0;
      repeat (5 * FRAME) begin
         @(negedge in_clk);
         if (frame_done) fd_cnt++;
      end
      check_eq("fd_count", 32'(fd_cnt), 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
